// File: rtl/ex_stage.sv
// Execute stage: ALU, branch target/condition, and an optional 32-cycle shift-add multiplier.
// Define EX_STAGE_MUL_EN to implement R-type MUL (funct 0x18); otherwise MUL decodes as a NOP.
module ex_stage (
  input  logic        clk,
  input  logic        reset,
  input  logic        valid_in,
  output logic        ready_out,
  input  logic [31:0] pc4_in_f_id,
  input  logic [5:0]  opcode,
  input  logic [31:0] rs_reg_value,
  input  logic [31:0] rt_reg_value,
  input  logic [31:0] i_data,
  input  logic        branch,
  input  logic        mem_read,
  input  logic        mem_to_reg,
  input  logic        mem_write,
  output logic        valid_out,
  output logic [31:0] alu_out,
  output logic [31:0] addr_in,
  output logic [31:0] write_data,
  output logic        rw,
  output logic        mem_read_out,
  output logic        mem_to_reg_out,
  output logic [31:0] ex_add,
  output logic        branch_taken
);

`ifdef EX_STAGE_MUL_EN
  localparam logic MUL_EN = 1'b1;
`else
  localparam logic MUL_EN = 1'b0;
`endif

  typedef enum logic {S_IDLE, S_MUL_BUSY} state_t;

  state_t      r_state;
  state_t      w_state_next;
  logic        w_accept;
  logic        w_legal;
  logic        w_is_mul;
  logic [31:0] w_alu;
  logic [31:0] w_ex_add;
  logic        w_taken;
  logic        w_rw;
  logic [31:0] w_prod_next;

  logic        r_valid;
  logic [31:0] r_alu;
  logic [31:0] r_wdata;
  logic [31:0] r_ex_add;
  logic        r_rw;
  logic        r_taken;
  logic        r_mr;
  logic        r_m2r;

  // Multiplier working registers plus the instruction's side outputs, held until completion
  logic [31:0] r_mcand;
  logic [31:0] r_mplier;
  logic [31:0] r_prod;
  logic [4:0]  r_count;
  logic [31:0] r_mul_wdata;
  logic [31:0] r_mul_ex_add;
  logic [3:0]  r_mul_ctl;

  assign w_accept = valid_in & ready_out;

  always_comb begin
    w_alu    = '0;
    w_legal  = 1'b1;
    w_is_mul = 1'b0;
    case (opcode)
      6'h00: begin
        case (i_data[5:0])
          6'h20: w_alu = rs_reg_value + rt_reg_value;
          6'h22: w_alu = rs_reg_value - rt_reg_value;
          6'h24: w_alu = rs_reg_value & rt_reg_value;
          6'h25: w_alu = rs_reg_value | rt_reg_value;
          6'h2A: w_alu = {31'b0, $signed(rs_reg_value) < $signed(rt_reg_value)};
          6'h18: begin
            if (MUL_EN) w_is_mul = 1'b1;
            else        w_legal  = 1'b0;
          end
          default: w_legal = 1'b0;
        endcase
      end
      6'h08, 6'h23, 6'h2B: w_alu = rs_reg_value + i_data;
      6'h04:               w_alu = rs_reg_value - rt_reg_value;
      default:             w_legal = 1'b0;
    endcase
  end

  assign w_ex_add    = pc4_in_f_id + {i_data[29:0], 2'b00};
  assign w_taken     = w_legal & branch & (rs_reg_value == rt_reg_value);
  assign w_rw        = w_legal & mem_write;
  assign w_prod_next = r_prod + (r_mplier[0] ? r_mcand : 32'd0);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= S_IDLE;
    else        r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    ready_out    = 1'b0;
    case (r_state)
      S_IDLE: begin
        ready_out = 1'b1;
        if (w_accept && w_is_mul) w_state_next = S_MUL_BUSY;
      end
      S_MUL_BUSY: begin
        if (r_count == 5'd31) w_state_next = S_IDLE;
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_valid      <= 1'b0;
      r_alu        <= '0;
      r_wdata      <= '0;
      r_ex_add     <= '0;
      r_rw         <= 1'b0;
      r_taken      <= 1'b0;
      r_mr         <= 1'b0;
      r_m2r        <= 1'b0;
      r_mcand      <= '0;
      r_mplier     <= '0;
      r_prod       <= '0;
      r_count      <= '0;
      r_mul_wdata  <= '0;
      r_mul_ex_add <= '0;
      r_mul_ctl    <= '0;
    end else if (r_state == S_IDLE) begin
      if (w_accept && w_is_mul) begin
        r_valid      <= 1'b0;
        r_mcand      <= rs_reg_value;
        r_mplier     <= rt_reg_value;
        r_prod       <= '0;
        r_count      <= '0;
        r_mul_wdata  <= rt_reg_value;
        r_mul_ex_add <= w_ex_add;
        r_mul_ctl    <= {w_rw, w_taken, mem_read, mem_to_reg};
      end else if (w_accept) begin
        r_valid  <= 1'b1;
        r_alu    <= w_alu;
        r_wdata  <= rt_reg_value;
        r_ex_add <= w_ex_add;
        r_rw     <= w_rw;
        r_taken  <= w_taken;
        r_mr     <= mem_read;
        r_m2r    <= mem_to_reg;
      end else begin
        r_valid <= 1'b0;
      end
    end else begin
      r_prod   <= w_prod_next;
      r_mcand  <= r_mcand << 1;
      r_mplier <= r_mplier >> 1;
      r_count  <= r_count + 5'd1;
      // Final iteration: publish the product together with the held side outputs
      if (r_count == 5'd31) begin
        r_valid  <= 1'b1;
        r_alu    <= w_prod_next;
        r_wdata  <= r_mul_wdata;
        r_ex_add <= r_mul_ex_add;
        {r_rw, r_taken, r_mr, r_m2r} <= r_mul_ctl;
      end
    end
  end

  assign valid_out      = r_valid;
  assign alu_out        = r_alu;
  assign addr_in        = r_alu;
  assign write_data     = r_wdata;
  assign ex_add         = r_ex_add;
  assign rw             = r_rw;
  assign branch_taken   = r_taken;
  assign mem_read_out   = r_mr;
  assign mem_to_reg_out = r_m2r;

endmodule
